prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: program memory address of the first payload byte.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  upstream byte stream valid.
REQ-005 SHALL have port in_data  input  8  upstream byte.
REQ-006 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port restart  input  1  synchronous abort/relaunch request.
REQ-008 SHALL have port mem_we  output  1  program memory write strobe, one cycle per byte.
REQ-009 SHALL have port mem_addr  output  8  program memory write address.
REQ-010 SHALL have port mem_data  output  8  program memory write data.
REQ-011 SHALL have port core_run  output  1  high releases the CPU core from reset.
REQ-012 SHALL have port load_err  output  1  sticky checksum failure flag.
REQ-013 SHALL have port bytes_loaded  output  9  payload bytes written in the current stream.

Function
REQ-014 SHALL accept a byte on a rising edge iff in_valid=1 and in_ready=1; no other edge changes stream state.
REQ-015 SHALL implement states IDLE, LOAD, CHECK, RUN, ERROR.
REQ-016 SHALL drive in_ready = (state is IDLE, LOAD or CHECK) AND restart=0 AND rst=1.
REQ-017 IDLE: accepted byte is the length L; L=0 means 256; SHALL load a 9-bit down-counter with L (256 for 0), clear checksum and bytes_loaded, go to LOAD.
REQ-018 LOAD: each accepted byte SHALL be added mod 256 into the checksum, and the next cycle SHALL have mem_we=1, mem_addr=(BASE_ADDR+bytes_loaded_before) mod 256, mem_data=byte; bytes_loaded increments on the accept edge.
REQ-019 mem_we SHALL be 0 in every cycle not directly following a LOAD accept; mem_addr/mem_data hold their last values when mem_we=0.
REQ-020 LOAD SHALL go to CHECK on the accept edge of the last payload byte (counter reaching 0).
REQ-021 CHECK: accepted byte C; if (checksum + C) mod 256 = 0, go to RUN, else go to ERROR.
REQ-022 core_run SHALL be registered, going 1 on the edge entering RUN, i.e. visible the cycle after the checksum accept, and SHALL stay 1 while in RUN.
REQ-023 load_err SHALL go 1 on the edge entering ERROR and stay 1 until restart or reset.
REQ-024 RUN and ERROR SHALL ignore in_valid (in_ready=0).
REQ-025 restart=1 in any state SHALL return to IDLE on the next edge, clearing core_run, load_err, bytes_loaded and counter; restart wins over a simultaneous in_valid (no byte accepted).
REQ-026 A pending mem_we from the accept edge before restart SHALL still complete; no further writes follow.
REQ-027 Address arithmetic SHALL wrap mod 256; bytes_loaded SHALL reach 256 for L=0 without overflow.
REQ-028 No gap requirement: back-to-back accepts on consecutive cycles SHALL produce consecutive writes.

Reset
REQ-029 While rst=0: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_data=0, core_run=0, load_err=0, bytes_loaded=0, counter and checksum 0.
REQ-030 Reset asserted mid-operation SHALL abort immediately (asynchronously); after release the first accepted byte is a length byte.

Verification
REQ-031 Stream 03,11,22,33,9A with in_valid continuous -> writes (00,11),(01,22),(02,33) on consecutive cycles, bytes_loaded=3, core_run=1 the cycle after 9A accept, in_ready=0 thereafter.
REQ-032 Stream 03,11,22,33,00 -> no core_run, load_err=1, in_ready=0; restart pulse -> IDLE, load_err=0, in_ready=1 next cycle.
REQ-033 BASE_ADDR=F0, length 00, 256 bytes of 01, checksum 00 -> addresses F0..FF then 00..EF, bytes_loaded=256, core_run=1.
REQ-034 Stream 02,AA,55,01 with in_valid toggling every other cycle -> exactly two mem_we pulses at 00,01; core_run=1.
REQ-035 rst=0 asserted after two payload bytes of a length-4 stream -> all outputs 0 immediately; after release new stream 01,7F,81 loads 7F at 00 and sets core_run.
REQ-036 In RUN, restart=1 and in_valid=1 same cycle -> byte not accepted, core_run=0 and state IDLE next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - boot loader streaming a length/payload/checksum image into program memory
//
// Purpose: accepts a byte stream of the form <length> <payload...> <checksum>,
// writes each payload byte to program memory starting at BASE_ADDR, then either
// releases the CPU core (checksum good) or raises a sticky error flag.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_ready     loader accepts a byte this cycle
//   restart      synchronous abort/relaunch request
//   mem_we       program memory write strobe (one cycle per payload byte)
//   mem_addr     program memory write address
//   mem_data     program memory write data
//   core_run     high releases the CPU core from reset
//   load_err     sticky checksum failure flag
//   bytes_loaded payload bytes written in the current stream (0..256)
module prog_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       restart,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       core_run,
  output logic       load_err,
  output logic [8:0] bytes_loaded
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] remaining;
  logic [7:0] checksum;
  logic [7:0] check_total;
  logic       accept;

  // in_ready includes rst so nothing looks acceptable while reset is held,
  // and restart so a relaunch never swallows a byte.
  always_comb begin
    in_ready = 1'b0;
    if (rst && !restart &&
        (state == IDLE || state == LOAD || state == CHECK)) begin
      in_ready = 1'b1;
    end
  end

  assign accept      = in_valid & in_ready;
  assign check_total = checksum + in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = IDLE;
    end else if (accept) begin
      case (state)
        IDLE:    state_next = LOAD;
        LOAD:    if (remaining == 9'd1) state_next = CHECK;
        CHECK:   state_next = (check_total == 8'd0) ? RUN : ERROR;
        default: state_next = state;
      endcase
    end
  end

  // Datapath. mem_we is a registered copy of the LOAD accept, so a write
  // launched on the edge before a restart still appears for its one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining    <= 9'd0;
      checksum     <= 8'd0;
      bytes_loaded <= 9'd0;
      mem_we       <= 1'b0;
      mem_addr     <= 8'd0;
      mem_data     <= 8'd0;
      core_run     <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      mem_we   <= 1'b0;
      core_run <= (state_next == RUN);
      load_err <= (state_next == ERROR);
      if (restart) begin
        remaining    <= 9'd0;
        checksum     <= 8'd0;
        bytes_loaded <= 9'd0;
      end else if (accept) begin
        case (state)
          IDLE: begin
            // A length byte of zero encodes a full 256-byte payload.
            remaining    <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            checksum     <= 8'd0;
            bytes_loaded <= 9'd0;
          end
          LOAD: begin
            checksum     <= checksum + in_data;
            remaining    <= remaining - 9'd1;
            bytes_loaded <= bytes_loaded + 9'd1;
            mem_we       <= 1'b1;
            mem_addr     <= BASE_ADDR + bytes_loaded[7:0];
            mem_data     <= in_data;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       restart = 1'b0;

  logic       rdy0, we0, run0, err0;
  logic [7:0] addr0, data0;
  logic [8:0] bl0;
  logic       rdy1, we1, run1, err1;
  logic [7:0] addr1, data1;
  logic [8:0] bl1;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  wr_t obs0[$];
  wr_t obs1[$];

  prog_loader #(.BASE_ADDR(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .restart(restart), .mem_we(we0), .mem_addr(addr0),
    .mem_data(data0), .core_run(run0), .load_err(err0), .bytes_loaded(bl0)
  );

  prog_loader #(.BASE_ADDR(8'hF0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .restart(restart), .mem_we(we1), .mem_addr(addr1),
    .mem_data(data1), .core_run(run1), .load_err(err1), .bytes_loaded(bl1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #1;
    if (we0) obs0.push_back('{cyc, addr0, data0});
    if (we1) obs1.push_back('{cyc, addr1, data1});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!rdy0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  // Builds <len> <payload> <checksum>; a bad stream gets a nonzero residue.
  function automatic byte_q_t make_stream(input int len, input bit good,
                                          input bit fixed, input logic [7:0] fill);
    byte_q_t s;
    int sum = 0;
    logic [7:0] b;
    s.push_back(8'(len % 256));
    for (int k = 0; k < len; k++) begin
      b = fixed ? fill : 8'($urandom);
      s.push_back(b);
      sum += b;
    end
    sum = (256 - (sum % 256)) % 256;
    if (!good) sum = (sum + 1 + int'($urandom_range(254))) % 256;
    s.push_back(8'(sum));
    return s;
  endfunction

  // gap: 0 back-to-back, 1 alternate cycles, 2 random idle cycles
  task automatic send_stream(input byte_q_t s, input int gap);
    int len, sum, bad_seq;
    bit exp_run;
    len = (s[0] == 8'd0) ? 256 : int'(s[0]);
    sum = 0;
    for (int k = 1; k <= len + 1; k++) sum += s[k];
    exp_run = (sum % 256) == 0;
    obs0.delete();
    obs1.delete();
    for (int k = 0; k < s.size(); k++) begin
      if (k == s.size() - 1) check("run_early", {31'd0, run0}, 32'd0);
      send_byte(s[k]);
      if (k < s.size() - 1) begin
        if (gap == 1) idle_cycles(1);
        else if (gap == 2) idle_cycles($urandom_range(3));
      end
    end
    #1;
    check("core_run0", {31'd0, run0}, {31'd0, exp_run});
    check("core_run1", {31'd0, run1}, {31'd0, exp_run});
    check("load_err0", {31'd0, err0}, {31'd0, !exp_run});
    check("in_ready_done", {31'd0, rdy0}, 32'd0);
    check("bytes_loaded0", {23'd0, bl0}, len);
    check("bytes_loaded1", {23'd0, bl1}, len);
    idle_cycles(3);
    check("in_ready_hold", {31'd0, rdy0 | rdy1}, 32'd0);
    check("run_hold", {31'd0, run0}, {31'd0, exp_run});
    check("wr_count0", obs0.size(), len);
    check("wr_count1", obs1.size(), len);
    bad_seq = 0;
    for (int k = 0; k < len && k < obs0.size() && k < obs1.size(); k++) begin
      check("wr_addr0", obs0[k].addr, k % 256);
      check("wr_data0", obs0[k].data, s[k + 1]);
      check("wr_addr1", obs1[k].addr, (8'hF0 + k) % 256);
      check("wr_data1", obs1[k].data, s[k + 1]);
      if (k > 0 && obs0[k].cyc != obs0[k - 1].cyc + 1) bad_seq++;
    end
    if (gap == 0) check("wr_back_to_back", bad_seq, 0);
  endtask

  task automatic do_restart();
    @(negedge clk);
    in_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    #1;
    check("rs_load_err", {30'd0, err0, err1}, 32'd0);
    check("rs_core_run", {30'd0, run0, run1}, 32'd0);
    check("rs_bytes", {23'd0, bl0}, 32'd0);
    check("rs_in_ready", {30'd0, rdy0, rdy1}, 32'd3);
  endtask

  initial begin
    byte_q_t s;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, rdy0}, 32'd0);
    check("rst_outs", {we0, addr0, data0, run0, err0, bl0}, 32'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, rdy0}, 32'd1);

    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_stream(s, 0);
    do_restart();

    s = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send_stream(s, 0);
    check("err_sticky", {31'd0, err0}, 32'd1);
    do_restart();

    s = '{8'h02, 8'hAA, 8'h55, 8'h01};
    send_stream(s, 1);
    do_restart();

    send_stream(make_stream(256, 1'b1, 1'b1, 8'h01), 0);
    do_restart();

    // asynchronous reset in the middle of a payload
    send_byte(8'h04);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    #2;
    rst = 1'b0;
    #1;
    check("arst_in_ready", {30'd0, rdy0, rdy1}, 32'd0);
    check("arst_outs0", {we0, addr0, data0, run0, err0, bl0}, 32'd0);
    check("arst_outs1", {we1, addr1, data1, run1, err1, bl1}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    s = '{8'h01, 8'h7F, 8'h81};
    send_stream(s, 0);

    // restart in RUN beats a simultaneous valid byte
    @(negedge clk);
    restart  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'($urandom_range(255, 1));
    #1;
    check("rs_run_ready", {31'd0, rdy0}, 32'd0);
    @(posedge clk);
    #1;
    check("rs_run_core", {31'd0, run0}, 32'd0);
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rs_run_idle", {31'd0, rdy0}, 32'd1);
    send_stream(make_stream(5, 1'b1, 1'b0, 8'h00), 2);
    do_restart();

    // restart right after a payload accept: that write still lands
    obs0.delete();
    s = make_stream(5, 1'b1, 1'b0, 8'h00);
    send_byte(s[0]);
    send_byte(s[1]);
    send_byte(s[2]);
    @(negedge clk);
    restart = 1'b1;
    in_data = s[3];
    @(negedge clk);
    restart  = 1'b0;
    in_valid = 1'b0;
    idle_cycles(3);
    check("pend_wr_count", obs0.size(), 2);
    if (obs0.size() == 2) check("pend_wr_data", obs0[1].data, s[2]);
    check("pend_bytes", {23'd0, bl0}, 32'd0);

    for (int it = 0; it < 12; it++) begin
      send_stream(make_stream($urandom_range(24, 1), ($urandom % 4) != 0, 1'b0, 8'h00),
                  $urandom % 3);
      do_restart();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
